drop_sequencer: RTL
===================

// Module: drop_sequencer
// PURPOSE
//   Sequential controller for the baggage-drop datapath. On a request it latches
//   height, t_lim and drop_en, computes t_act = sqrt(height)/2 (Q8.8) with a
//   bit-serial square-root engine, compares t_act with t_lim, then asserts
//   drop_activated for a fixed hold window. Replaces the combinational
//   sqrt/compare path with a clocked, abortable transaction.
// PARAMETERS
//   HOLD_CYCLES  16  cycles drop_activated stays high after a grant (legal range 1..65535)
// PORTS
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   req             in   1   start request, sampled only in IDLE
//   abort           in   1   cancel current transaction, any non-IDLE state
//   height          in   8   unsigned integer height from sensor stage
//   t_lim           in   16  time limit, Q8.8 unsigned
//   drop_en         in   1   drop permission, latched with req
//   busy            out  1   high in every state except IDLE
//   done            out  1   one-cycle pulse when the comparison result is valid
//   drop_ok         out  1   result of the last completed compare, held until next done
//   t_act           out  16  last computed time, Q8.8, held until next done
//   drop_activated  out  1   drop actuator, high only in HOLD
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy, done, drop_ok, drop_activated = 0;
//     t_act = 0; all internal registers = 0.
//   States: IDLE -> SQRT -> CMP -> HOLD|IDLE.
//   IDLE: at an edge with req=1, latch height, t_lim, drop_en; load radicand
//     {height,16'h0} (24 b); clear root (12 b) and remainder; iter=11; go SQRT.
//   SQRT: restoring digit-by-digit root, one result bit per cycle, exactly 12
//     cycles, MSB first. After the final iteration, go CMP.
//     root = floor(sqrt(height*65536)) = floor(sqrt(height)*256), Q4.8.
//   CMP (1 cycle): t_act <= {5'b0, root[11:1]} (root/2, truncated, Q8.8);
//     drop_ok <= drop_en_l && (t_act_new <= t_lim_l). Equality grants.
//     done=1 for this one cycle (registered output, visible in the cycle after the CMP edge).
//     If drop_ok=1 go HOLD with counter=HOLD_CYCLES-1, else go IDLE.
//   HOLD: drop_activated=1; decrement counter each cycle; at 0 go IDLE.
//     drop_activated is high for exactly HOLD_CYCLES cycles.
//   Latency: req sampled at edge N -> done high after edge N+13.
//   req while busy: ignored, not queued. req held high: a new transaction
//     starts at the first IDLE edge after HOLD/CMP ends.
//   abort=1 at an edge in SQRT/CMP/HOLD: go IDLE; drop_activated=0;
//     no done pulse; t_act/drop_ok keep their previous values.
//     abort wins over a simultaneous CMP completion. abort in IDLE: no effect,
//     and the simultaneous req is ignored.
//   Input changes after latching have no effect on the running transaction.
//   height=0 -> root=0, t_act=0. No overflow is possible: max root is 4087.
//   Reset asserted mid-transaction: immediate return to reset values,
//     including drop_activated=0 with no clock edge.
// TESTING
//   1. height=100, t_lim=16'h0500, drop_en=1, req pulse -> done at +13 cycles,
//      t_act=16'h0500, drop_ok=1, drop_activated high 16 cycles, then busy=0.
//   2. height=100, t_lim=16'h04FF, drop_en=1 -> t_act=16'h0500, drop_ok=0,
//      drop_activated never rises, IDLE the cycle after done.
//   3. height=255 -> t_act=16'h07FB; height=2 -> 16'h00B5; height=0 -> 16'h0000.
//   4. height=64, t_lim=16'hFFFF, drop_en=0 -> t_act=16'h0400, drop_ok=0.
//   5. abort at SQRT cycle 5, then abort in HOLD cycle 3 -> IDLE next edge,
//      no done, drop_activated drops immediately, t_act unchanged.
//   6. rst_n low during HOLD, and req pulses while busy -> outputs zero asynchronously;
//      ignored reqs produce no extra transaction. Exhaustive sweep height=0..255
//      vs floor(sqrt(h*65536))>>1 reference model.

Source files
------------

// File: rtl/drop_sequencer.sv
// drop_sequencer: clocked, abortable replacement for the combinational
// sqrt/compare path of the baggage-drop datapath. A request latches the
// operands, a restoring bit-serial engine produces floor(sqrt(height)*256),
// the halved root (Q8.8) is compared against the latched limit, and a grant
// holds the drop actuator for HOLD_CYCLES cycles.
module drop_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        abort,
  input  logic [7:0]  height,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        done,
  output logic        drop_ok,
  output logic [15:0] t_act,
  output logic        drop_activated
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQRT = 2'd1,
    CMP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state;
  logic [23:0] rad;        // radicand, consumed two bits per iteration
  logic [11:0] root;       // partial root, one bit appended per iteration
  logic [12:0] rem;        // partial remainder, always <= 2*root < 2^13
  logic [3:0]  iter;       // remaining iterations after the current one
  logic [15:0] t_lim_l;
  logic        drop_en_l;
  logic [15:0] hold_cnt;

  // Halve the Q4.8 root into Q8.8 by truncation; the top bits are zero
  // because the root never exceeds 4087.
  function automatic logic [15:0] half_root_q88(input logic [10:0] root_hi);
    return {5'b00000, root_hi};
  endfunction

  logic [14:0] rem_sh;
  logic [14:0] trial;
  logic [14:0] rem_diff;
  logic [14:0] rem_nx;
  logic        fit;
  logic [15:0] t_act_new;
  logic        ok_new;
  logic        unused_rem_hi;

  // One restoring square-root step plus the compare result used in CMP.
  always_comb begin
    rem_sh    = {rem, rad[23:22]};
    trial     = {1'b0, root, 2'b01};
    fit       = (rem_sh >= trial);
    rem_diff  = rem_sh - trial;
    rem_nx    = fit ? rem_diff : rem_sh;
    t_act_new = half_root_q88(root[11:1]);
    ok_new    = drop_en_l && (t_act_new <= t_lim_l);
  end

  // The remainder bound guarantees the two top bits of the step result are zero.
  assign unused_rem_hi = ^rem_nx[14:13];

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rad            <= '0;
      root           <= '0;
      rem            <= '0;
      iter           <= '0;
      t_lim_l        <= '0;
      drop_en_l      <= 1'b0;
      hold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      drop_ok        <= 1'b0;
      t_act          <= '0;
      drop_activated <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !abort) begin
            rad       <= {height, 16'h0000};
            root      <= '0;
            rem       <= '0;
            iter      <= 4'd11;
            t_lim_l   <= t_lim;
            drop_en_l <= drop_en;
            busy      <= 1'b1;
            state     <= SQRT;
          end
        end
        SQRT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem  <= rem_nx[12:0];
            root <= {root[10:0], fit};
            rad  <= {rad[21:0], 2'b00};
            if (iter == 4'd0) begin
              state <= CMP;
            end else begin
              iter <= iter - 4'd1;
            end
          end
        end
        CMP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            t_act   <= t_act_new;
            drop_ok <= ok_new;
            done    <= 1'b1;
            if (ok_new) begin
              hold_cnt       <= HOLD_LOAD;
              drop_activated <= 1'b1;
              state          <= HOLD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (abort || hold_cnt == 16'd0) begin
            drop_activated <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          drop_activated <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
